// File: rtl/array_rw_frontend_if.sv
// Request/response and RW0 macro port bundle for array_rw_frontend.
// The slave modport is the frontend's view; the master modport is the pipeline/macro side.
interface array_rw_frontend_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 137
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, RW0_rdata,
    output wr_ready, rd_ready, resp_valid, resp_data, RW0_en, RW0_wmode, RW0_addr, RW0_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, RW0_rdata,
    input  wr_ready, rd_ready, resp_valid, resp_data, RW0_en, RW0_wmode, RW0_addr, RW0_wdata
  );
endinterface

// File: rtl/array_rw_frontend.sv
// Arbitrates write/read channels onto one single-port RW0 array port and buffers read data
// in a credit-checked response FIFO. Define ARRAY_FE_RR_ARB_EN for round-robin arbitration.
module array_rw_frontend #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 137,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  array_rw_frontend_if.slave bus
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(RESP_DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [DATA_W-1:0] mem_q [RESP_DEPTH];
  logic [DATA_W-1:0] mem_d [RESP_DEPTH];

  logic              credit_ok;
  logic              rd_elig;
  logic              wr_rdy;
  logic              rd_rdy;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              push;
  logic              pop;
  logic              resp_vld;
  logic [ADDR_W-1:0] addr_mux;

  // A read may only issue if a FIFO slot is reserved for it, counting the read still in flight.
  assign credit_ok = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_EXT;
  assign rd_elig   = bus.rd_valid && credit_ok;

`ifdef ARRAY_FE_RR_ARB_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    wr_rdy       = !reset && (!rd_elig || last_grant_q);
    rd_rdy       = !reset && credit_ok && (!bus.wr_valid || !last_grant_q);
    last_grant_d = last_grant_q;
    if (wr_gnt) begin
      last_grant_d = 1'b0;
    end else if (rd_gnt) begin
      last_grant_d = 1'b1;
    end
  end
`else
  always_comb begin
    wr_rdy = !reset;
    rd_rdy = !reset && credit_ok && !bus.wr_valid;
  end
`endif

  assign wr_gnt = bus.wr_valid && wr_rdy;
  assign rd_gnt = bus.rd_valid && rd_rdy;

  always_comb begin
    addr_mux      = wr_gnt ? bus.wr_addr : bus.rd_addr;
    bus.wr_ready  = wr_rdy;
    bus.rd_ready  = rd_rdy;
    bus.RW0_en    = wr_gnt || rd_gnt;
    bus.RW0_wmode = wr_gnt;
    bus.RW0_addr  = addr_mux;
    bus.RW0_wdata = bus.wr_data;
  end

  assign resp_vld       = !reset && (count_q != '0);
  assign bus.resp_valid = resp_vld;
  assign bus.resp_data  = mem_q[head_q];
  assign push           = inflight_q;
  assign pop            = resp_vld && bus.resp_ready;

  always_comb begin
    inflight_d = rd_gnt;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d     = head_q;
    tail_d     = tail_q;
    mem_d      = mem_q;
    if (push) begin
      mem_d[tail_q] = bus.RW0_rdata;
      tail_d        = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      inflight_q   <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
`ifdef ARRAY_FE_RR_ARB_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
`ifdef ARRAY_FE_RR_ARB_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_array_rw_frontend.sv
// Scoreboard bench for array_rw_frontend with a behavioural RW0 macro and a reference memory.
// Directed scenarios plus randomized traffic; build with ARRAY_FE_RR_ARB_EN for round-robin mode.
module tb_array_rw_frontend;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 137;
  localparam int RESP_DEPTH = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  array_rw_frontend_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  array_rw_frontend #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(RESP_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural single-port macro: registered read, write at the edge ending the cycle.
  logic [DATA_W-1:0] macro_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] macro_rdata = '0;
  assign bus.RW0_rdata = macro_rdata;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.RW0_en) begin
      if (bus.RW0_wmode) begin
        macro_mem[bus.RW0_addr] = bus.RW0_wdata;
      end else begin
        macro_rdata <= macro_mem.exists(bus.RW0_addr) ? macro_mem[bus.RW0_addr] : '0;
      end
    end
  end

  // Reference: memory content as seen at acceptance time, and expected responses in order.
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] exp_q [$];
  int                acc_q [$];
  bit                grant_log [$];
  bit                log_en = 1'b0;
  bit                last_kind = 1'b0;
  int                wr_acc = 0;
  int                rd_acc = 0;
  int                resp_cnt = 0;
  int                last_lat = 0;
  int                last_pop_cyc = -10;
  int                run = 0;
  logic [DATA_W-1:0] last_resp = '0;
  logic              wh, rh;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_output_data(input string name, input logic [DATA_W-1:0] act,
                                   input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: responses are checked before this cycle's acceptances are recorded.
  always @(negedge clock) begin
    if (reset) begin
      last_kind = 1'b0;
    end else begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_resp", 1, 0);
        end else begin
          check_output_data("resp_data", bus.resp_data, exp_q[0]);
          if (bus.resp_ready) begin
            void'(exp_q.pop_front());
            last_lat  = cyc - acc_q.pop_front();
            last_resp = bus.resp_data;
            check_output("latency_min", int'(last_lat >= 2), 1);
            run = (cyc == last_pop_cyc + 1) ? run + 1 : 1;
            last_pop_cyc = cyc;
            resp_cnt++;
          end
        end
      end
      wh = bus.wr_valid && bus.wr_ready;
      rh = bus.rd_valid && bus.rd_ready;
      check_output("single_grant", int'(wh && rh), 0);
      if (rh) begin
        exp_q.push_back(ref_mem.exists(bus.rd_addr) ? ref_mem[bus.rd_addr] : '0);
        acc_q.push_back(cyc);
        rd_acc++;
        last_kind = 1'b1;
        if (log_en) grant_log.push_back(1'b1);
      end
      if (wh) begin
        ref_mem[bus.wr_addr] = bus.wr_data;
        wr_acc++;
        last_kind = 1'b0;
        if (log_en) grant_log.push_back(1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic wv, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic rv,
                                input logic [ADDR_W-1:0] ra);
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] tmp;
    tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return tmp[DATA_W-1:0];
  endfunction

  task automatic wait_resp(input int target, input int budget);
    int n = 0;
    while (resp_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check_output("resp_wait", int'(resp_cnt >= target), 1);
  endtask

  task automatic drain();
    int n = 0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    bus.resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    check_output("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), rand_data(),
                     1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int acc0;
    int n;
    bit prev;
    bit exp_kind;
    logic [DATA_W-1:0] first_val;

    // Reset with both request channels asserted: every output must stay low.
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    apply_stimulus(1'b1, 12'h001, '1, 1'b1, 12'h002);
    tick();
    tick();
    check_output("rst_resp_valid", int'(bus.resp_valid), 0);
    check_output("rst_wr_ready", int'(bus.wr_ready), 0);
    check_output("rst_rd_ready", int'(bus.rd_ready), 0);
    check_output("rst_RW0_en", int'(bus.RW0_en), 0);
    check_output("rst_RW0_wmode", int'(bus.RW0_wmode), 0);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b0;
    tick();

    // Write then read one address: response two cycles after acceptance.
    first_val = 137'h1_23456789abcdef0123456789abcdef0123;
    apply_stimulus(1'b1, 12'h005, first_val, 1'b0, '0);
    #1;
    check_output("wr_ready_idle", int'(bus.wr_ready), 1);
    tick();
    base = resp_cnt;
    apply_stimulus(1'b0, '0, '0, 1'b1, 12'h005);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    wait_resp(base + 1, 10);
    check_output("first_latency", last_lat, 2);
    check_output_data("first_data", last_resp, first_val);

    rand_phase(60);
    drain();

    // Eight back-to-back reads with the consumer always ready.
    base = resp_cnt;
    acc0 = rd_acc;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, ADDR_W'($urandom_range(0, 15)));
      #1;
      check_output("b2b_rd_ready", int'(bus.rd_ready), 1);
      tick();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    wait_resp(base + 8, 20);
    check_output("b2b_accepted", rd_acc - acc0, 8);
    check_output("b2b_consecutive", run, 8);

    // Consumer stalled: exactly RESP_DEPTH reads accepted, then reads resume on release.
    bus.resp_ready = 1'b0;
    acc0 = rd_acc;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, ADDR_W'($urandom_range(0, 15)));
      tick();
    end
    check_output("full_accepted", rd_acc - acc0, RESP_DEPTH);
    check_output("full_rd_ready", int'(bus.rd_ready), 0);
    bus.resp_ready = 1'b1;
    n = 0;
    while (rd_acc <= acc0 + RESP_DEPTH && n < 10) begin
      tick();
      n++;
    end
    check_output("full_resume", int'(rd_acc > acc0 + RESP_DEPTH), 1);
    drain();

    // Read followed by a write to the same address: the read sees the old value.
    apply_stimulus(1'b1, 12'h010, 137'h55, 1'b0, '0);
    tick();
    base = resp_cnt;
    apply_stimulus(1'b0, '0, '0, 1'b1, 12'h010);
    tick();
    apply_stimulus(1'b1, 12'h010, 137'hAA, 1'b0, '0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    wait_resp(base + 1, 10);
    check_output_data("raw_old_value", last_resp, 137'h55);
    apply_stimulus(1'b0, '0, '0, 1'b1, 12'h010);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    wait_resp(base + 2, 10);
    check_output_data("raw_new_value", last_resp, 137'hAA);
    drain();

    // Both channels requesting for six cycles.
    prev = last_kind;
    grant_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, ADDR_W'(32 + i), rand_data(), 1'b1, ADDR_W'($urandom_range(0, 15)));
      tick();
    end
    log_en = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    check_output("arb_grants", grant_log.size(), 6);
    exp_kind = !prev;
    for (int i = 0; i < grant_log.size(); i++) begin
`ifdef ARRAY_FE_RR_ARB_EN
      check_output("arb_kind", int'(grant_log[i]), int'(exp_kind));
      exp_kind = !exp_kind;
`else
      check_output("arb_kind", int'(grant_log[i]), 0);
`endif
    end
    drain();

    // Reset with two responses buffered and one read in flight.
    bus.resp_ready = 1'b0;
    acc0 = rd_acc;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, ADDR_W'($urandom_range(0, 15)));
      tick();
    end
    check_output("prerst_accepted", rd_acc - acc0, 3);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_output("midrst_resp_valid", int'(bus.resp_valid), 0);
    tick();
    reset = 1'b0;
    tick();
    check_output("postrst_resp_valid", int'(bus.resp_valid), 0);
    bus.resp_ready = 1'b1;
    base = resp_cnt;
    for (int i = 0; i < 6; i++) tick();
    check_output("postrst_no_stale", resp_cnt, base);

    rand_phase(300);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/array_rw_frontend.md
# array_rw_frontend

Request-side controller for the single-port array macros (`RW0_*` port, 1-cycle registered read, 137-bit data). It accepts independent valid/ready write and read request channels, arbitrates them onto the one shared RW0 port at one access per cycle, and captures the returned read data into a response FIFO. The FIFO has credit-based flow control, so no read data is ever lost. It sits between pipeline logic and an `array_*_ext` instance; the parent ties the macro's `RW0_clk` to `clock`.

## Interface
- `ADDR_W`, 12: address width.
- `DATA_W`, 137: data width.
- `RESP_DEPTH`, 3: response FIFO entries; must be ≥ 2.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  write request valid.
- `wr_ready`  out  1  write accepted this cycle when high together with `wr_valid`.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_valid`  in  1  read request valid.
- `rd_ready`  out  1  read accepted this cycle when high together with `rd_valid`.
- `rd_addr`  in  ADDR_W  read address.
- `resp_valid`  out  1  FIFO head valid.
- `resp_ready`  in  1  consumer pops the head.
- `resp_data`  out  DATA_W  read data, returned in request order.
- `RW0_en`, `RW0_wmode`  out  1 each  macro enable and write mode.
- `RW0_addr`  out  ADDR_W  macro address.
- `RW0_wdata`  out  DATA_W  macro write data.
- `RW0_rdata`  in  DATA_W  macro read data, valid in the cycle after the read issues.

## Operation
- State:
  - `count`: FIFO occupancy, 0..RESP_DEPTH.
  - `inflight`: 1 bit, high in the cycle after a read issues.
  - `last_grant`: 1 bit, used only in round-robin mode.
- Read eligibility: `rd_valid && (count + inflight < RESP_DEPTH)`. A pop in the same cycle does not return a credit, so there is no combinational path from `resp_ready`.
- Write eligibility: `wr_valid`.
- Arbitration: see Configuration. At most one grant per cycle.
- Port drive:
  - `RW0_en` = any grant.
  - `RW0_wmode` = write grant.
  - `RW0_addr` = address of the granted channel (`rd_addr` when idle).
  - `RW0_wdata` = `wr_data` at all times.
- `wr_ready`/`rd_ready` equal their grant signals. A ready may depend on the other channel's valid, but never on its own valid.
- Capture: when `inflight` is 1, `RW0_rdata` is pushed into the FIFO at the clock edge that ends that cycle.
- `inflight` next value = read grant this cycle.
- `count` next value = `count` + push − (`resp_valid && resp_ready`).
- Ordering:
  - A write issued in the cycle where an earlier read's data is captured does not affect that data. The read returns the pre-write value.
  - Responses are strictly FIFO.
- `resp_data` is the FIFO head. It stays stable while `resp_valid && !resp_ready`.
- FIFO full: `count + inflight` reaches `RESP_DEPTH` → `rd_ready` = 0. Writes continue unaffected.
- Empty: `resp_valid` = 0 and `resp_data` is don't-care.

## Timing
- Reset (synchronous), while `reset` is high:
  - `count` = 0, `inflight` = 0, `last_grant` = write.
  - `resp_valid` = 0, `wr_ready` = 0, `rd_ready` = 0, `RW0_en` = 0, `RW0_wmode` = 0.
- Reset mid-operation: in-flight and buffered read data is discarded. A write already presented at the edge before reset asserts has completed.
- Read latency: request accepted in cycle t → `resp_valid` high in cycle t+2, earliest.
- Throughput:
  - With `RESP_DEPTH` = 3 and `resp_ready` held high, back-to-back reads sustain 1 per cycle.
  - Writes sustain 1 per cycle.
- Write takes effect at the edge ending its grant cycle.

## Configuration
- `ARRAY_FE_RR_ARB_EN` undefined (fixed priority):
  - Write always wins over an eligible read.
  - Reads may starve under continuous writes.
- `ARRAY_FE_RR_ARB_EN` defined (round robin):
  - When both channels are eligible, grant the channel opposite `last_grant`.
  - `last_grant` updates on every grant.
  - Single eligible channel: grant it.

## Test plan
- Reset, then write addr 0x005 data 0x1_2345…, then read 0x005 → `resp_valid` at t+2, `resp_data` = written value; all outputs 0 during reset.
- 8 back-to-back reads with `resp_ready`=1 → `rd_ready` stays 1, 8 responses on consecutive cycles, in order.
- `resp_ready`=0, issue reads → exactly 3 accepted, then `rd_ready`=0. Release `resp_ready` → 3 responses in order, reads resume.
- Read 0x010 at t, write 0x010 ← 0xAA at t+1 → response holds the old value; a subsequent read returns 0xAA.
- `wr_valid` and `rd_valid` held high for 6 cycles:
  - Without macro: 6 writes, 0 reads.
  - With `ARRAY_FE_RR_ARB_EN`: alternating W,R,W,R,W,R.
- Assert `reset` with 2 responses buffered and 1 in flight → after release, `resp_valid`=0 and no stale responses appear.
